efuse_autoload: RTL and testbench

Power-on and software-triggered load sequencer for the eFuse array. Sits directly upstream of the eFuse read engine: it issues one word-read per `read_sel` slice, waits for completion, and assembles the full array image into a shadow register. The shadow register feeds the trim and config consumers. It also flags completion, timeout and, optionally, checksum failure to the digital top.

---
 rtl/efuse_pkg.sv | 20 ++
 rtl/efuse_autoload_if.sv | 35 +++
 rtl/efuse_xor_chk.sv | 22 ++
 rtl/efuse_autoload.sv | 123 ++++++++++++
 tb/tb_efuse_autoload.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/efuse_pkg.sv
// rtl/efuse_pkg.sv - shared types and constants for the eFuse autoload slice
//
// Purpose: FSM state encoding and array-wide constants used by the
//          autoload sequencer, its read-engine interface and the bench.
// Ports:   none (package).
package efuse_pkg;

  localparam int EFUSE_BITS  = 256;  // full eFuse array image in bits
  localparam int EFUSE_TMO_W = 12;   // per-word timeout counter width

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } efuse_load_state_e;

endpackage

// File: rtl/efuse_autoload_if.sv
// rtl/efuse_autoload_if.sv - handshake between the autoload sequencer and the eFuse read engine
//
// Purpose: bundles the word-read request/response signals.
// Ports (master = sequencer side):
//   read_sel   out  word index presented to the read engine
//   read_start out  single-cycle start pulse
//   read_done  in   engine done level, data valid while high
//   busy_read  in   engine busy level
//   read_data  in   word returned by the engine
interface efuse_autoload_if
  import efuse_pkg::*;
#(
  parameter int NR   = 64,
  parameter int RSEL = EFUSE_BITS / NR
);

  localparam int SW = (RSEL > 1) ? $clog2(RSEL) : 1;

  logic [SW-1:0] read_sel;
  logic          read_start;
  logic          read_done;
  logic          busy_read;
  logic [NR-1:0] read_data;

  modport master (
    output read_sel, read_start,
    input  read_done, busy_read, read_data
  );

  modport slave (
    input  read_sel, read_start,
    output read_done, busy_read, read_data
  );

endinterface

// File: rtl/efuse_xor_chk.sv
// rtl/efuse_xor_chk.sv - combinational byte-wise XOR reduction
//
// Purpose: folds a W-bit vector into one byte by XOR-ing all W/8 bytes.
//          A correctly programmed image reduces to 8'h00.
// Ports:
//   data      in  W  vector to reduce (W multiple of 8)
//   xor_byte  out 8  XOR of all bytes of data
module efuse_xor_chk #(
  parameter int W = 256
) (
  input  logic [W-1:0] data,
  output logic [7:0]   xor_byte
);

  always_comb begin
    xor_byte = '0;
    for (int b = 0; b < W / 8; b++) begin
      xor_byte = xor_byte ^ data[b*8 +: 8];
    end
  end

endmodule

// File: rtl/efuse_autoload.sv
// rtl/efuse_autoload.sv - power-on / software-triggered eFuse array load sequencer
//
// Purpose: reads the eFuse array one word at a time through the read engine
//          and assembles the image into a shadow register. Optional image
//          checksum is built only when EFUSE_LOAD_CHK_EN is defined.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   load_auto_en  strap: start one load right after reset release
//   load_req      single-cycle software reload request
//   rg_load_tmo   per-word timeout in cycles, 0 disables
//   rd            read-engine handshake (master side)
//   shadow_data   assembled array image
//   load_busy     load in progress
//   load_done     last load stored every word
//   load_err      last load aborted on timeout
//   chk_err       checksum mismatch on last completed load (0 without EFUSE_LOAD_CHK_EN)
module efuse_autoload
  import efuse_pkg::*;
#(
  parameter int NR   = 64,
  parameter int RSEL = EFUSE_BITS / NR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_auto_en,
  input  logic                   load_req,
  input  logic [EFUSE_TMO_W-1:0] rg_load_tmo,
  efuse_autoload_if.master       rd,
  output logic [NR*RSEL-1:0]     shadow_data,
  output logic                   load_busy,
  output logic                   load_done,
  output logic                   load_err,
  output logic                   chk_err
);

  localparam int            SW       = (RSEL > 1) ? $clog2(RSEL) : 1;
  localparam logic [SW-1:0] LAST_IDX = SW'(RSEL - 1);

  efuse_load_state_e      state, state_nxt;
  logic [SW-1:0]          idx;
  logic [EFUSE_TMO_W-1:0] tmo_cnt;
  logic                   auto_armed;  // high only in the first cycle after reset release
  logic                   start_load;
  logic [NR*RSEL-1:0]     shadow_nxt;  // image with the current word merged in

  always_comb begin
    state_nxt  = state;
    start_load = 1'b0;
    case (state)
      ST_IDLE:  if ((auto_armed && load_auto_en) || load_req) start_load = 1'b1;
      ST_DONE,
      ST_ERR:   if (load_req) start_load = 1'b1;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        // A completed read takes priority over a timeout in the same cycle.
        if (rd.read_done && !rd.busy_read)                  state_nxt = ST_STORE;
        else if (rg_load_tmo != '0 && tmo_cnt == rg_load_tmo) state_nxt = ST_ERR;
      end
      ST_STORE: state_nxt = (idx == LAST_IDX) ? ST_DONE : ST_ISSUE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (start_load) state_nxt = ST_ISSUE;
  end

  always_comb begin
    shadow_nxt                = shadow_data;
    shadow_nxt[idx*NR +: NR]  = rd.read_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      tmo_cnt     <= '0;
      auto_armed  <= 1'b1;
      shadow_data <= '0;
    end else begin
      state      <= state_nxt;
      auto_armed <= 1'b0;
      if (start_load) begin
        idx         <= '0;
        shadow_data <= '0;
      end else if (state == ST_STORE) begin
        shadow_data <= shadow_nxt;
        if (idx != LAST_IDX) idx <= idx + 1'b1;
      end
      // Cleared while in ISSUE so the first WAIT cycle sees 0; saturates.
      if (state == ST_ISSUE)
        tmo_cnt <= '0;
      else if (state == ST_WAIT && tmo_cnt != '1)
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // idx only changes on edges into ISSUE, so it doubles as the held read_sel.
  assign rd.read_sel   = idx;
  assign rd.read_start = (state == ST_ISSUE);
  assign load_busy     = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_STORE);
  assign load_done     = (state == ST_DONE);
  assign load_err      = (state == ST_ERR);

`ifdef EFUSE_LOAD_CHK_EN
  logic [7:0] img_xor;

  efuse_xor_chk #(.W(NR*RSEL)) u_xor_chk (
    .data     (shadow_nxt),
    .xor_byte (img_xor)
  );

  // Evaluated on the final STORE so the flag rises together with load_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      chk_err <= 1'b0;
    else if (start_load)
      chk_err <= 1'b0;
    else if (state == ST_STORE && idx == LAST_IDX)
      chk_err <= |img_xor;
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_efuse_autoload.sv
// tb/tb_efuse_autoload.sv - self-checking bench for efuse_autoload
module tb_efuse_autoload;
  import efuse_pkg::*;

  localparam int NR   = 64;
  localparam int RSEL = 4;
  localparam int IW   = NR * RSEL;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           load_auto_en = 1'b0;
  logic           load_req = 1'b0;
  logic [11:0]    rg_load_tmo = 12'd100;
  logic [IW-1:0]  shadow_data;
  logic           load_busy, load_done, load_err, chk_err;

  efuse_autoload_if #(.NR(NR), .RSEL(RSEL)) rd_if ();

  efuse_autoload #(.NR(NR), .RSEL(RSEL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_auto_en (load_auto_en),
    .load_req     (load_req),
    .rg_load_tmo  (rg_load_tmo),
    .rd           (rd_if),
    .shadow_data  (shadow_data),
    .load_busy    (load_busy),
    .load_done    (load_done),
    .load_err     (load_err),
    .chk_err      (chk_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // read engine model contents: per-word data and latency (0 = never completes)
  logic [NR-1:0] mem [RSEL];
  int            lat [RSEL];

  // monitor state
  int cyc = 0;
  int t0 = -1;
  int t_end = -1;
  int n_start = 0;
  int sel_log [$];
  int cur = 0;
  int rem = 0;

  // Read engine model and monitor; runs on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_if.read_done = 1'b0;
      rd_if.busy_read = 1'b0;
      rem = 0;
    end else begin
      cyc++;
      if (t0 >= 0 && t_end < 0 && (load_done || load_err)) t_end = cyc;
      if (rd_if.read_start) begin
        if (t0 < 0) t0 = cyc;
        n_start++;
        sel_log.push_back(int'(rd_if.read_sel));
        cur = int'(rd_if.read_sel);
        rd_if.read_done = 1'b0;
        rd_if.busy_read = 1'b1;
        rem = lat[cur];
      end else if (rd_if.busy_read && rem > 0) begin
        rem--;
        if (rem == 0) begin
          rd_if.busy_read = 1'b0;
          rd_if.read_done = 1'b1;
          rd_if.read_data = mem[cur];
        end
      end
    end
  end

  initial rd_if.read_data = '0;

  task automatic chk(input string nm, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] img_xor(input logic [IW-1:0] img);
    logic [7:0] x;
    x = '0;
    for (int b = 0; b < IW / 8; b++) x ^= img[b*8 +: 8];
    return x;
  endfunction

  // Behavioural outcome of one load from the per-word latencies and timeout.
  // A word whose done appears in WAIT cycle L succeeds when L <= tmo+1.
  task automatic ref_model(output bit e_err, output int e_nst, output int e_dur,
                           output logic [IW-1:0] e_img);
    int tmo;
    bit tout;
    tmo = int'(rg_load_tmo);
    e_err = 0; e_nst = 0; e_dur = 0; e_img = '0;
    for (int w = 0; w < RSEL; w++) begin
      tout = (tmo != 0) && (lat[w] == 0 || lat[w] > tmo + 1);
      if (tout) begin
        e_err = 1;
        e_dur += 1 + tmo + 1;
        break;
      end
      e_img[w*NR +: NR] = mem[w];
      e_dur += lat[w] + 2;
      e_nst++;
    end
  endtask

  task automatic clear_mon();
    t0 = -1; t_end = -1; n_start = 0;
    sel_log.delete();
  endtask

  task automatic pulse_req();
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    for (int i = 0; i < 3000 && t_end < 0; i++) @(negedge clk);
    @(negedge clk);
    if (t_end < 0) begin
      total++; bad++;
      $display("FAIL %s_no_end actual=none expected=done_or_err", tag);
    end
  endtask

  // Compare the finished load against the reference model; returns the measured duration.
  task automatic check_load(input string tag, output int dur, output bit got_err);
    bit e_err; int e_nst; int e_dur; logic [IW-1:0] e_img; bit e_chk; bit seq_ok;
    ref_model(e_err, e_nst, e_dur, e_img);
`ifdef EFUSE_LOAD_CHK_EN
    e_chk = !e_err && (img_xor(e_img) != 8'h00);
`else
    e_chk = 1'b0;
`endif
    dur = t_end - t0;
    got_err = load_err;
    seq_ok = 1;
    foreach (sel_log[i]) if (sel_log[i] != i) seq_ok = 0;
    chk({tag, "_done"},   load_done,   !e_err);
    chk({tag, "_err"},    load_err,    e_err);
    chk({tag, "_busy"},   load_busy,   1'b0);
    chk({tag, "_chk"},    chk_err,     e_chk);
    chk({tag, "_image"},  shadow_data, e_img);
    chk({tag, "_dur"},    dur,         e_dur);
    chk({tag, "_starts"}, n_start,     e_err ? e_nst + 1 : RSEL);
    chk({tag, "_selseq"}, seq_ok,      1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rstart"}, rd_if.read_start, 1'b0);
    chk({tag, "_rsel"},   rd_if.read_sel,   '0);
    chk({tag, "_shadow"}, shadow_data,      '0);
    chk({tag, "_busy"},   load_busy,        1'b0);
    chk({tag, "_done"},   load_done,        1'b0);
    chk({tag, "_err"},    load_err,         1'b0);
    chk({tag, "_chk"},    chk_err,          1'b0);
  endtask

  typedef struct {
    int tmo;
    int lat2;      // latency of word 2, others are 2
    bit exp_err;
    int exp_dur;   // cycles from first ISSUE to DONE/ERR
  } vec_t;

  vec_t vt [7];

  initial begin
    int dur; bit gerr; logic [7:0] x; logic [IW-1:0] img;

    vt[0] = '{tmo: 20, lat2: 21, exp_err: 0, exp_dur: 35};  // done on the timeout cycle
    vt[1] = '{tmo: 20, lat2: 22, exp_err: 1, exp_dur: 30};
    vt[2] = '{tmo: 20, lat2: 0,  exp_err: 1, exp_dur: 30};  // word 2 never completes
    vt[3] = '{tmo: 20, lat2: 20, exp_err: 0, exp_dur: 34};
    vt[4] = '{tmo: 0,  lat2: 60, exp_err: 0, exp_dur: 74};  // timeout disabled
    vt[5] = '{tmo: 1,  lat2: 2,  exp_err: 0, exp_dur: 16};
    vt[6] = '{tmo: 1,  lat2: 3,  exp_err: 1, exp_dur: 11};

    // reset state
    load_auto_en = 1'b1;
    for (int w = 0; w < RSEL; w++) lat[w] = 3;
    mem[0] = 64'h0011223344556677;
    mem[1] = 64'h8899AABBCCDDEEFF;
    mem[2] = 64'h0102030405060708;
    mem[3] = 64'hA0A1A2A3A4A5A6A7;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");

    // auto load after reset release
    clear_mon();
    rst_n = 1'b1;
    wait_end("auto");
    check_load("auto", dur, gerr);
    img = {64'hA0A1A2A3A4A5A6A7, 64'h0102030405060708,
           64'h8899AABBCCDDEEFF, 64'h0011223344556677};
    chk("auto_image_const", shadow_data, img);
    chk("auto_dur_const", dur, 20);

    // reload from DONE, with a stray request during WAIT
    for (int w = 0; w < RSEL; w++) mem[w] = {$urandom, $urandom};
    clear_mon();
    pulse_req();
    chk("reload_done_low", load_done, 1'b0);
    chk("reload_shadow_clr", shadow_data, '0);
    chk("reload_busy", load_busy, 1'b1);
    repeat (2) @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    wait_end("reload");
    check_load("reload", dur, gerr);

    // timeout / simultaneous-event table
    for (int w = 0; w < RSEL; w++) mem[w] = {$urandom, $urandom};
    foreach (vt[i]) begin
      rg_load_tmo = 12'(vt[i].tmo);
      for (int w = 0; w < RSEL; w++) lat[w] = 2;
      lat[2] = vt[i].lat2;
      clear_mon();
      pulse_req();
      wait_end($sformatf("vec%0d", i));
      check_load($sformatf("vec%0d", i), dur, gerr);
      chk($sformatf("vec%0d_tbl_err", i), gerr, vt[i].exp_err);
      chk($sformatf("vec%0d_tbl_dur", i), dur, vt[i].exp_dur);
    end

    // checksum: good image, then bit 0 of word 3 flipped
    rg_load_tmo = 12'd50;
    for (int w = 0; w < RSEL; w++) begin
      mem[w] = {$urandom, $urandom};
      lat[w] = 4;
    end
    for (int w = 0; w < RSEL; w++) img[w*NR +: NR] = mem[w];
    x = img_xor(img);
    mem[3][7:0] = mem[3][7:0] ^ x;
    clear_mon();
    pulse_req();
    wait_end("chk_good");
    check_load("chk_good", dur, gerr);
    chk("chk_good_flag", chk_err, 1'b0);
    mem[3][0] = ~mem[3][0];
    clear_mon();
    pulse_req();
    wait_end("chk_bad");
    check_load("chk_bad", dur, gerr);
`ifdef EFUSE_LOAD_CHK_EN
    chk("chk_bad_flag", chk_err, 1'b1);
`else
    chk("chk_bad_flag", chk_err, 1'b0);
`endif
    chk("chk_bad_done", load_done, 1'b1);

    // randomized loads against the reference model
    for (int r = 0; r < 10; r++) begin
      rg_load_tmo = ($urandom_range(0, 2) == 0) ? 12'd0 : 12'($urandom_range(1, 9));
      for (int w = 0; w < RSEL; w++) begin
        mem[w] = {$urandom, $urandom};
        lat[w] = $urandom_range(2, 10);
        if (rg_load_tmo != 0 && $urandom_range(0, 7) == 0) lat[w] = 0;
      end
      clear_mon();
      pulse_req();
      wait_end($sformatf("rnd%0d", r));
      check_load($sformatf("rnd%0d", r), dur, gerr);
    end

    // reset during word 1 WAIT, then auto load restarts from word 0
    rg_load_tmo = 12'd100;
    for (int w = 0; w < RSEL; w++) begin
      mem[w] = {$urandom, $urandom};
      lat[w] = 6;
    end
    clear_mon();
    pulse_req();
    for (int i = 0; i < 200 && sel_log.size() < 2; i++) @(negedge clk);
    chk("midrst_reached_w1", sel_log.size(), 2);
    repeat (2) @(negedge clk);
    chk("midrst_busy_before", load_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(negedge clk);
    clear_mon();
    rst_n = 1'b1;
    wait_end("after_rst");
    check_load("after_rst", dur, gerr);
    chk("after_rst_first_sel", (sel_log.size() > 0) ? sel_log[0] : -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
